// File: rtl/pkt_frame_monitor_if.sv
// rtl/pkt_frame_monitor_if.sv - flit bus observed by the packet framing monitor
interface pkt_frame_monitor_if #(
  parameter int CH_W = 2
) ();
  logic            valid;
  logic            head;
  logic            tail;
  logic [CH_W-1:0] chan;

  modport master (output valid, output head, output tail, output chan);
  modport slave  (input  valid, input  head, input  tail, input  chan);
endinterface

// File: rtl/pkt_frame_monitor.sv
// rtl/pkt_frame_monitor.sv - per-channel packet framing checker with done/err reporting
module pkt_frame_monitor #(
  parameter int NCH     = 4,
  parameter int CH_W    = 2,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  pkt_frame_monitor_if.slave   flit,
  output logic                 done,
  output logic [CH_W-1:0]      done_ch,
  output logic [LEN_W-1:0]     done_len,
  output logic                 err,
  output logic [CH_W-1:0]      err_ch,
  output logic [1:0]           err_code,
  output logic [7:0]           err_cnt,
  output logic [2*NCH-1:0]     state_vec
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAD = 2'b01,
    ST_DATA = 2'b10,
    ST_TAIL = 2'b11
  } ch_state_e;

  localparam logic [1:0]     E_NO_HEAD     = 2'd0;
  localparam logic [1:0]     E_HEAD_IN_PKT = 2'd1;
  localparam logic [1:0]     E_TOO_LONG    = 2'd2;
  localparam logic [1:0]     E_BAD_CH      = 2'd3;
  localparam logic [CH_W:0]  NCH_L         = (CH_W+1)'(NCH);
  localparam logic [LEN_W:0] MAX_L         = (LEN_W+1)'(MAX_LEN);

  ch_state_e          st_q  [NCH];
  ch_state_e          st_d  [NCH];
  logic [LEN_W-1:0]   len_q [NCH];
  logic [LEN_W-1:0]   len_d [NCH];

  logic               done_q, done_d;
  logic [CH_W-1:0]    done_ch_q, done_ch_d;
  logic [LEN_W-1:0]   done_len_q, done_len_d;
  logic               err_q, err_d;
  logic [CH_W-1:0]    err_ch_q, err_ch_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic               in_range;
  logic               sel;
  logic               start;
  logic [LEN_W:0]     next_len;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      st_d[c]  = st_q[c];
      len_d[c] = len_q[c];
    end
    done_d     = 1'b0;
    done_ch_d  = done_ch_q;
    done_len_d = done_len_q;
    err_d      = 1'b0;
    err_ch_d   = err_ch_q;
    err_code_d = err_code_q;
    err_cnt_d  = err_cnt_q;
    sel        = 1'b0;
    start      = 1'b0;
    next_len   = '0;

    in_range = ({1'b0, flit.chan} < NCH_L);

    if (flit.valid && !in_range) begin
      err_d      = 1'b1;
      err_ch_d   = flit.chan;
      err_code_d = E_BAD_CH;
    end

    for (int c = 0; c < NCH; c++) begin
      sel      = flit.valid && in_range && (flit.chan == CH_W'(c));
      start    = 1'b0;
      next_len = {1'b0, len_q[c]} + 1'b1;
      if (sel) begin
        if (st_q[c] == ST_HEAD || st_q[c] == ST_DATA) begin
          if (flit.head) begin
            // The interrupted packet is dropped; this flit opens a fresh one.
            err_d      = 1'b1;
            err_ch_d   = flit.chan;
            err_code_d = E_HEAD_IN_PKT;
            start      = 1'b1;
          end else if (next_len > MAX_L) begin
            err_d      = 1'b1;
            err_ch_d   = flit.chan;
            err_code_d = E_TOO_LONG;
            st_d[c]    = ST_IDLE;
            len_d[c]   = '0;
          end else if (flit.tail) begin
            st_d[c]    = ST_TAIL;
            len_d[c]   = next_len[LEN_W-1:0];
            done_d     = 1'b1;
            done_ch_d  = flit.chan;
            done_len_d = next_len[LEN_W-1:0];
          end else begin
            st_d[c]  = ST_DATA;
            len_d[c] = next_len[LEN_W-1:0];
          end
        end else if (flit.head) begin
          start = 1'b1;
        end else begin
          err_d      = 1'b1;
          err_ch_d   = flit.chan;
          err_code_d = E_NO_HEAD;
          st_d[c]    = ST_IDLE;
          len_d[c]   = '0;
        end

        if (start) begin
          len_d[c] = LEN_W'(1);
          if (flit.tail) begin
            st_d[c]    = ST_TAIL;
            done_d     = 1'b1;
            done_ch_d  = flit.chan;
            done_len_d = LEN_W'(1);
          end else begin
            st_d[c] = ST_HEAD;
          end
        end
      end else if (st_q[c] == ST_TAIL) begin
        // TAIL lasts exactly one cycle unless a new packet arrives on top of it.
        st_d[c] = ST_IDLE;
      end
    end

    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        st_q[c]  <= ST_IDLE;
        len_q[c] <= '0;
      end
      done_q     <= 1'b0;
      done_ch_q  <= '0;
      done_len_q <= '0;
      err_q      <= 1'b0;
      err_ch_q   <= '0;
      err_code_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        st_q[c]  <= st_d[c];
        len_q[c] <= len_d[c];
      end
      done_q     <= done_d;
      done_ch_q  <= done_ch_d;
      done_len_q <= done_len_d;
      err_q      <= err_d;
      err_ch_q   <= err_ch_d;
      err_code_q <= err_code_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_vec = '0;
    for (int c = 0; c < NCH; c++) begin
      state_vec[2*c +: 2] = st_q[c];
    end
  end

  assign done     = done_q;
  assign done_ch  = done_ch_q;
  assign done_len = done_len_q;
  assign err      = err_q;
  assign err_ch   = err_ch_q;
  assign err_code = err_code_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_pkt_frame_monitor.sv
// tb/tb_pkt_frame_monitor.sv - directed bench for pkt_frame_monitor (NCH=4 and NCH=3 instances)
module tb_pkt_frame_monitor;
  logic clk;
  logic reset;

  logic       done,  err;
  logic [1:0] done_ch, err_ch, err_code;
  logic [4:0] done_len;
  logic [7:0] err_cnt;
  logic [7:0] state_vec;

  logic       done3, err3;
  logic [1:0] done_ch3, err_ch3, err_code3;
  logic [4:0] done_len3;
  logic [7:0] err_cnt3;
  logic [5:0] state_vec3;

  int n_tests = 0;
  int n_fail  = 0;

  pkt_frame_monitor_if #(.CH_W(2)) f ();
  pkt_frame_monitor_if #(.CH_W(2)) g ();

  pkt_frame_monitor #(.NCH(4), .CH_W(2), .MAX_LEN(16), .LEN_W(5)) dut (
    .clk(clk), .reset(reset), .flit(f.slave),
    .done(done), .done_ch(done_ch), .done_len(done_len),
    .err(err), .err_ch(err_ch), .err_code(err_code),
    .err_cnt(err_cnt), .state_vec(state_vec)
  );

  pkt_frame_monitor #(.NCH(3), .CH_W(2), .MAX_LEN(16), .LEN_W(5)) dut3 (
    .clk(clk), .reset(reset), .flit(g.slave),
    .done(done3), .done_ch(done_ch3), .done_len(done_len3),
    .err(err3), .err_ch(err_ch3), .err_code(err_code3),
    .err_cnt(err_cnt3), .state_vec(state_vec3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of flit inputs (called at a negedge); returns at the next
  // negedge, when the registered result of that flit is visible.
  task automatic put(input logic v, input logic h, input logic t, input logic [1:0] ch);
    f.valid = v;
    f.head  = h;
    f.tail  = t;
    f.chan  = ch;
    @(negedge clk);
  endtask

  initial begin
    f.valid = 1'b0; f.head = 1'b0; f.tail = 1'b0; f.chan = 2'd0;
    g.valid = 1'b0; g.head = 1'b0; g.tail = 1'b0; g.chan = 2'd0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_state_vec", 32'(state_vec), 32'h0);
    check_eq("rst_done",      32'(done), 32'h0);
    check_eq("rst_err",       32'(err), 32'h0);
    check_eq("rst_err_cnt",   32'(err_cnt), 32'h0);
    check_eq("rst_done_len",  32'(done_len), 32'h0);
    check_eq("rst_err_code",  32'(err_code), 32'h0);
    reset = 1'b0;

    // ch1: head, data, data, tail
    put(1, 1, 0, 1); check_eq("c1_head_st", 32'(state_vec[3:2]), 32'h1);
    put(1, 0, 0, 1); check_eq("c1_d1_st",   32'(state_vec[3:2]), 32'h2);
    put(1, 0, 0, 1); check_eq("c1_d2_st",   32'(state_vec[3:2]), 32'h2);
    check_eq("c1_d2_done", 32'(done), 32'h0);
    put(1, 0, 1, 1); check_eq("c1_tail_st", 32'(state_vec[3:2]), 32'h3);
    check_eq("c1_done",     32'(done), 32'h1);
    check_eq("c1_done_ch",  32'(done_ch), 32'h1);
    check_eq("c1_done_len", 32'(done_len), 32'h4);
    // valid=0 ignores head/tail/chan; TAIL auto-returns to IDLE
    put(0, 1, 1, 1); check_eq("c1_ret_st", 32'(state_vec[3:2]), 32'h0);
    check_eq("nv_done", 32'(done), 32'h0);
    check_eq("nv_err",  32'(err), 32'h0);
    check_eq("hold_done_len", 32'(done_len), 32'h4);

    // ch1 single-flit packet then ch0 single-flit: ch1 TAIL returns while ch0 is addressed
    put(1, 1, 1, 1); check_eq("sf_c1_st", 32'(state_vec), 32'h0C);
    put(1, 1, 1, 0); check_eq("sf_c0_st", 32'(state_vec), 32'h03);
    check_eq("sf_c0_done_ch", 32'(done_ch), 32'h0);
    put(0, 0, 0, 0); check_eq("sf_idle_st", 32'(state_vec), 32'h0);

    // interleaved ch0/ch2
    put(1, 1, 0, 0);
    put(1, 1, 0, 2); check_eq("il_st", 32'(state_vec), 32'h11);
    put(1, 0, 1, 0); check_eq("il_d0", 32'(done), 32'h1);
    check_eq("il_d0_ch", 32'(done_ch), 32'h0);
    check_eq("il_d0_len", 32'(done_len), 32'h2);
    put(1, 0, 0, 2); check_eq("il_mid_done", 32'(done), 32'h0);
    put(1, 0, 1, 2); check_eq("il_d2", 32'(done), 32'h1);
    check_eq("il_d2_ch", 32'(done_ch), 32'h2);
    check_eq("il_d2_len", 32'(done_len), 32'h3);
    check_eq("il_err_cnt", 32'(err_cnt), 32'h0);
    put(0, 0, 0, 0);

    // ch3 data while IDLE, then single-flit packet
    put(1, 0, 0, 3); check_eq("nh_err", 32'(err), 32'h1);
    check_eq("nh_code", 32'(err_code), 32'h0);
    check_eq("nh_ch",   32'(err_ch), 32'h3);
    check_eq("nh_st",   32'(state_vec[7:6]), 32'h0);
    put(1, 1, 1, 3); check_eq("ht_done", 32'(done), 32'h1);
    check_eq("ht_len", 32'(done_len), 32'h1);
    check_eq("ht_err", 32'(err), 32'h0);
    check_eq("ht_hold_err_ch", 32'(err_ch), 32'h3);
    check_eq("ht_err_cnt", 32'(err_cnt), 32'h1);
    put(0, 0, 0, 0);

    // length limit on ch0: 16 legal, 17 too long
    put(1, 1, 0, 0);
    for (int i = 0; i < 14; i++) put(1, 0, 0, 0);
    put(1, 0, 1, 0); check_eq("ml_done", 32'(done), 32'h1);
    check_eq("ml_len", 32'(done_len), 32'd16);
    put(0, 0, 0, 0);
    put(1, 1, 0, 0);
    for (int i = 0; i < 15; i++) put(1, 0, 0, 0);
    check_eq("tl_pre_st", 32'(state_vec[1:0]), 32'h2);
    put(1, 0, 1, 0); check_eq("tl_err", 32'(err), 32'h1);
    check_eq("tl_code", 32'(err_code), 32'h2);
    check_eq("tl_done", 32'(done), 32'h0);
    check_eq("tl_st",   32'(state_vec[1:0]), 32'h0);
    check_eq("tl_err_cnt", 32'(err_cnt), 32'h2);

    // head inside packet on ch2
    put(1, 1, 0, 2);
    put(1, 0, 0, 2);
    put(1, 1, 0, 2); check_eq("hp_err", 32'(err), 32'h1);
    check_eq("hp_code", 32'(err_code), 32'h1);
    check_eq("hp_ch",   32'(err_ch), 32'h2);
    check_eq("hp_st",   32'(state_vec[5:4]), 32'h1);
    check_eq("hp_done", 32'(done), 32'h0);
    put(1, 0, 1, 2); check_eq("hp_len", 32'(done_len), 32'h2);
    check_eq("hp_done2", 32'(done), 32'h1);
    put(1, 1, 0, 2); check_eq("hp_tail_head_err", 32'(err), 32'h0);
    put(1, 1, 1, 2); check_eq("hb_err", 32'(err), 32'h1);
    check_eq("hb_done", 32'(done), 32'h1);
    check_eq("hb_len",  32'(done_len), 32'h1);
    check_eq("hb_st",   32'(state_vec[5:4]), 32'h3);
    check_eq("hb_err_cnt", 32'(err_cnt), 32'h4);
    put(0, 0, 0, 0);

    // bad channel on the NCH=3 instance
    g.valid = 1'b1; g.head = 1'b1; g.tail = 1'b0; g.chan = 2'd3;
    @(negedge clk);
    g.valid = 1'b0;
    check_eq("bc_err",  32'(err3), 32'h1);
    check_eq("bc_code", 32'(err_code3), 32'h3);
    check_eq("bc_ch",   32'(err_ch3), 32'h3);
    check_eq("bc_st",   32'(state_vec3), 32'h0);
    check_eq("bc_cnt",  32'(err_cnt3), 32'h1);
    @(negedge clk);
    check_eq("bc_pulse", 32'(err3), 32'h0);

    // err_cnt saturation
    for (int i = 0; i < 100; i++) put(1, 0, 0, 1);
    check_eq("sat_mid", 32'(err_cnt), 32'd104);
    for (int i = 0; i < 200; i++) put(1, 0, 0, 1);
    check_eq("sat_full", 32'(err_cnt), 32'd255);
    put(0, 0, 0, 0);

    // reset mid-packet on ch0 overrides the flit in that cycle
    put(1, 1, 0, 0);
    put(1, 0, 0, 0);
    reset = 1'b1;
    put(1, 0, 1, 0);
    reset = 1'b0;
    check_eq("rm_st",   32'(state_vec), 32'h0);
    check_eq("rm_cnt",  32'(err_cnt), 32'h0);
    check_eq("rm_done", 32'(done), 32'h0);
    check_eq("rm_err",  32'(err), 32'h0);
    put(1, 0, 1, 0); check_eq("rm_nh_err", 32'(err), 32'h1);
    check_eq("rm_nh_code", 32'(err_code), 32'h0);
    check_eq("rm_nh_done", 32'(done), 32'h0);
    put(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
